dram_ctl: RTL and testbench
===========================

// Module: dram_ctl
// PURPOSE
//  Main-RAM controller for the Playground 68030 board. It responds to the
//  nDRAMSEL decode from the system controller and runs one 32-bit FPM DRAM
//  SIMM bank. It drives RAS/CAS/WE and the multiplexed address, and terminates
//  the bus cycle with asynchronous DSACK (32-bit port). It also performs
//  periodic CAS-before-RAS refresh.
// PARAMETERS
//  ROW_BITS      11   row address width; also the MA width
//  COL_BITS      11   column address width (<= ROW_BITS, zero-extended onto MA)
//  TRCD           2   RAS->CAS delay in DRAM_CLK cycles (>= 2)
//  TRP            3   RAS precharge, in clocks
//  TRAS           4   nRAS low time during refresh, in clocks
//  REFRESH_CLKS 780   refresh interval in clocks (15.6us at 50MHz)
// PORTS
//  DRAM_CLK   in   1    50MHz clock; CPU_CLK = DRAM_CLK/2
//  nRST       in   1    asynchronous, active-low reset
//  nAS        in   1    CPU address strobe
//  nDS        in   1    CPU data strobe
//  RnW        in   1    1 = read
//  SIZ        in   2    68030 transfer size
//  nDRAMSEL   in   1    RAM region select from the system controller
//  ADDR       in   ROW_BITS+COL_BITS+2   CPU byte address
//  MA         out  ROW_BITS   multiplexed DRAM address
//  nRAS       out  1    row strobe
//  nCAS       out  4    column strobes; nCAS[3-i] = byte offset i (nCAS[3] = D31:24)
//  nWE        out  1    write enable
//  DSACK      out  2    active-high; an external open-drain inverter drives /DSACK1:0
// BEHAVIOUR
//  - Reset (async): nRAS=1, nCAS=4'hF, nWE=1, DSACK=0, MA=0, state IDLE,
//    refresh pending=0, refresh counter=REFRESH_CLKS-1. A reset mid-cycle aborts
//    the cycle immediately. All outputs are registered.
//  - Request: req_q <= ~nAS & ~nDRAMSEL, registered on every rising DRAM_CLK.
//  - Row = ADDR[COL_BITS+ROW_BITS+1:COL_BITS+2]; col = ADDR[COL_BITS+1:2].
//  - States: IDLE, RCD, CAS, HOLD, REF_CAS, REF_RAS, PRE.
//  - IDLE: MA=row.
//      - refresh pending -> REF_CAS. This takes priority over a simultaneous req_q.
//      - else req_q -> RCD: nRAS=0; nWE=0 if write.
//  - RCD: lasts TRCD clocks. MA=row on the first clock, col thereafter.
//      - Exit to CAS requires read, or nDS sampled low on a write.
//      - A write with nDS high waits in RCD with no timeout.
//  - CAS: nCAS and DSACK=2'b11 asserted on the same edge, then -> HOLD.
//      - Reads: nCAS=4'b0000.
//      - Writes: lanes per the 68030 byte-enable table (SIZ 00=long, 01=byte,
//        10=word, 11=3-byte), clipped at offset 3.
//  - HOLD: nRAS, nCAS, nWE and DSACK are held until nAS is sampled high.
//      - Then all release on the same edge -> PRE.
//  - Abort: nAS high while in RCD -> nRAS=1, nWE=1, no CAS, no DSACK -> PRE.
//      - This also covers cycles ended by the BERR watchdog.
//  - PRE: nRAS high for TRP clocks -> IDLE.
//  - Refresh counter: decrements every clock regardless of state.
//      - At 0: reload REFRESH_CLKS-1 and set pending.
//      - Expiry while already pending leaves pending=1 (it is not queued twice).
//  - REF_CAS: nCAS=4'h0 for 1 clock -> REF_RAS.
//  - REF_RAS: nRAS=0 for TRAS clocks, nCAS held low. Then both release and
//    pending clears -> PRE.
//  - DSACK is never asserted during refresh. nWE stays 1 during refresh.
//  - Read latency: req_q edge k; nRAS low k+1; nCAS and DSACK k+1+TRCD.
// TESTING
//  1. Assert nRST mid-HOLD -> next sample nRAS=1, nCAS=F, nWE=1, DSACK=0, MA=0;
//     the next request starts a fresh cycle.
//  2. Long read, ADDR=0x0012_3458, defaults:
//     - MA=0x091 at nRAS fall, MA=0x516 at nCAS fall.
//     - nCAS=0000, DSACK=11 at k+3, held until nAS rises.
//     - Then nRAS stays high for 3 clocks before the next nRAS fall.
//  3. Byte write, SIZ=01, ADDR[1:0]=2, nDS held high 5 clocks:
//     - nCAS stays F and DSACK=0 while nDS is high; nWE=0 from nRAS fall.
//     - After nDS falls: nCAS=1101, DSACK=11.
//  4. Idle with REFRESH_CLKS=16: every 16 clocks, nCAS=0000 one clock before
//     nRAS falls, nRAS low 4 clocks, DSACK=0, nWE=1.
//  5. Refresh pending and req_q rise on the same edge: refresh completes and
//     precharges 3 clocks, then the access runs with MA/nCAS as in test 2.
//  6. nAS negated one clock after nRAS fall: no nCAS edge, DSACK never
//     asserted, nRAS high for 3 clocks, back in IDLE.

Source files
------------

// File: rtl/dram_ctl.sv
// FPM DRAM controller for one 32-bit SIMM bank: RAS/CAS sequencing, multiplexed address,
// 32-bit DSACK termination and periodic CAS-before-RAS refresh. All outputs are registered.
module dram_ctl #(
  parameter int ROW_BITS     = 11,
  parameter int COL_BITS     = 11,
  parameter int TRCD         = 2,
  parameter int TRP          = 3,
  parameter int TRAS         = 4,
  parameter int REFRESH_CLKS = 780
) (
  input  logic                         DRAM_CLK,
  input  logic                         nRST,
  input  logic                         nAS,
  input  logic                         nDS,
  input  logic                         RnW,
  input  logic [1:0]                   SIZ,
  input  logic                         nDRAMSEL,
  input  logic [ROW_BITS+COL_BITS+1:0] ADDR,
  output logic [ROW_BITS-1:0]          MA,
  output logic                         nRAS,
  output logic [3:0]                   nCAS,
  output logic                         nWE,
  output logic [1:0]                   DSACK,
  output logic [2:0]                   fsm_state
);

  localparam int RCW = $clog2(REFRESH_CLKS);

  typedef enum logic [2:0] {IDLE, RCD, CAS, HOLD, REF_CAS, REF_RAS, PRE} state_t;

  state_t                state, state_nx;
  logic [7:0]            cnt, cnt_nx;
  logic                  req_q;
  logic                  ref_pend;
  logic                  ref_clr;
  logic [RCW-1:0]        ref_cnt;
  logic [ROW_BITS-1:0]   row, col;
  logic [ROW_BITS-1:0]   ma_nx;
  logic                  nras_nx, nwe_nx;
  logic [3:0]            ncas_nx, lanes;
  logic [1:0]            dsack_nx;

  assign row       = ADDR[ROW_BITS+COL_BITS+1:COL_BITS+2];
  assign col       = ROW_BITS'(ADDR[COL_BITS+1:2]);
  assign fsm_state = state;

  // 68030 byte-enable table for a 32-bit port; nCAS[3] is byte offset 0 (D31:24).
  always_comb begin
    lanes = 4'hF;
    case ({SIZ, ADDR[1:0]})
      4'b00_00: lanes = 4'b0000;
      4'b00_01: lanes = 4'b1000;
      4'b00_10: lanes = 4'b1100;
      4'b00_11: lanes = 4'b1110;
      4'b01_00: lanes = 4'b0111;
      4'b01_01: lanes = 4'b1011;
      4'b01_10: lanes = 4'b1101;
      4'b01_11: lanes = 4'b1110;
      4'b10_00: lanes = 4'b0011;
      4'b10_01: lanes = 4'b1001;
      4'b10_10: lanes = 4'b1100;
      4'b10_11: lanes = 4'b1110;
      4'b11_00: lanes = 4'b0001;
      4'b11_01: lanes = 4'b1000;
      4'b11_10: lanes = 4'b1100;
      4'b11_11: lanes = 4'b1110;
      default:  lanes = 4'hF;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ma_nx    = MA;
    nras_nx  = nRAS;
    ncas_nx  = nCAS;
    nwe_nx   = nWE;
    dsack_nx = DSACK;
    ref_clr  = 1'b0;
    case (state)
      IDLE: begin
        ma_nx = row;
        if (ref_pend) begin
          ncas_nx  = 4'h0;
          state_nx = REF_CAS;
        end else if (req_q) begin
          nras_nx  = 1'b0;
          nwe_nx   = RnW;
          cnt_nx   = '0;
          state_nx = RCD;
        end
      end
      RCD: begin
        ma_nx = col;
        if (nAS) begin
          nras_nx  = 1'b1;
          nwe_nx   = 1'b1;
          cnt_nx   = '0;
          state_nx = PRE;
        end else if (cnt >= 8'(TRCD - 1)) begin
          // A write waits here, without timeout, until the CPU's data strobe is seen.
          if (RnW || !nDS) begin
            ncas_nx  = RnW ? 4'h0 : lanes;
            dsack_nx = 2'b11;
            state_nx = CAS;
          end
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      CAS, HOLD: begin
        if (nAS) begin
          nras_nx  = 1'b1;
          ncas_nx  = 4'hF;
          nwe_nx   = 1'b1;
          dsack_nx = 2'b00;
          cnt_nx   = '0;
          state_nx = PRE;
        end else begin
          state_nx = HOLD;
        end
      end
      REF_CAS: begin
        nras_nx  = 1'b0;
        cnt_nx   = '0;
        state_nx = REF_RAS;
      end
      REF_RAS: begin
        if (cnt >= 8'(TRAS - 1)) begin
          nras_nx  = 1'b1;
          ncas_nx  = 4'hF;
          ref_clr  = 1'b1;
          cnt_nx   = '0;
          state_nx = PRE;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      PRE: begin
        // The IDLE clock that follows completes the TRP-clock precharge.
        if (cnt >= 8'(TRP - 2)) state_nx = IDLE;
        else                    cnt_nx   = cnt + 8'd1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge DRAM_CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      cnt      <= '0;
      req_q    <= 1'b0;
      ref_pend <= 1'b0;
      ref_cnt  <= RCW'(REFRESH_CLKS - 1);
      MA       <= '0;
      nRAS     <= 1'b1;
      nCAS     <= 4'hF;
      nWE      <= 1'b1;
      DSACK    <= 2'b00;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      req_q <= ~nAS & ~nDRAMSEL;
      MA    <= ma_nx;
      nRAS  <= nras_nx;
      nCAS  <= ncas_nx;
      nWE   <= nwe_nx;
      DSACK <= dsack_nx;
      if (ref_cnt == '0) begin
        ref_cnt  <= RCW'(REFRESH_CLKS - 1);
        ref_pend <= 1'b1;
      end else begin
        ref_cnt <= ref_cnt - 1'b1;
        if (ref_clr) ref_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dram_ctl.sv
// Directed and randomized bench for dram_ctl; expected timing comes from a transaction-level
// model of the access, precharge and refresh rules.
module tb_dram_ctl;
  localparam int ROW_BITS = 11;
  localparam int COL_BITS = 11;
  localparam int TRCD     = 2;
  localparam int TRP      = 3;
  localparam int TRAS     = 4;
  localparam int R        = 780;
  localparam int R16      = 16;
  localparam int AW       = ROW_BITS + COL_BITS + 2;

  logic                DRAM_CLK = 1'b0;
  logic                nRST = 1'b1;
  logic                nAS = 1'b1, nDS = 1'b1, RnW = 1'b1, nDRAMSEL = 1'b1;
  logic [1:0]          SIZ = 2'b00;
  logic [AW-1:0]       ADDR = '0;
  logic [ROW_BITS-1:0] MA, r_ma;
  logic                nRAS, nWE, r_nras, r_nwe;
  logic [3:0]          nCAS, r_ncas;
  logic [1:0]          DSACK, r_dsack;
  logic [2:0]          fsm_state, r_state;

  int checks = 0;
  int failures = 0;
  int n;              // rising edges since reset release
  int rel_n = -100;   // edge at which nRAS last went high

  dram_ctl dut (
    .DRAM_CLK(DRAM_CLK), .nRST(nRST), .nAS(nAS), .nDS(nDS), .RnW(RnW), .SIZ(SIZ),
    .nDRAMSEL(nDRAMSEL), .ADDR(ADDR), .MA(MA), .nRAS(nRAS), .nCAS(nCAS), .nWE(nWE),
    .DSACK(DSACK), .fsm_state(fsm_state)
  );

  dram_ctl #(.REFRESH_CLKS(R16)) dut16 (
    .DRAM_CLK(DRAM_CLK), .nRST(nRST), .nAS(1'b1), .nDS(1'b1), .RnW(1'b1), .SIZ(2'b00),
    .nDRAMSEL(1'b1), .ADDR({AW{1'b0}}), .MA(r_ma), .nRAS(r_nras), .nCAS(r_ncas), .nWE(r_nwe),
    .DSACK(r_dsack), .fsm_state(r_state)
  );

  always #10 DRAM_CLK = ~DRAM_CLK;

  always @(posedge DRAM_CLK or negedge nRST)
    if (!nRST) n <= 0;
    else       n <= n + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge DRAM_CLK);
  endtask

  function automatic logic [3:0] exp_lanes(input logic rnw, input logic [1:0] siz,
                                           input logic [1:0] off);
    logic [3:0] m;
    int nb;
    m = 4'hF;
    if (rnw) return 4'h0;
    nb = (siz == 2'b00) ? 4 : int'(siz);
    for (int i = 0; i < 4; i++)
      if (i >= int'(off) && i < int'(off) + nb) m[3-i] = 1'b0;
    return m;
  endfunction

  // Refresh: nCAS low at edge s, nRAS low for TRAS clocks from s+1, both released at s+1+TRAS.
  task automatic check_refresh(input string tag, input int s);
    while (n < s - 1) begin
      step();
      chk({tag, "/idle_ras"}, nRAS, 1);
      chk({tag, "/idle_cas"}, nCAS, 4'hF);
    end
    step();
    chk({tag, "/cas_first"}, nCAS, 4'h0);
    chk({tag, "/ras_still_hi"}, nRAS, 1);
    repeat (TRAS) begin
      step();
      chk({tag, "/ras_lo"}, nRAS, 0);
      chk({tag, "/cas_lo"}, nCAS, 4'h0);
      chk({tag, "/dsack"}, DSACK, 2'b00);
      chk({tag, "/nwe"}, nWE, 1);
    end
    step();
    chk({tag, "/ras_rel"}, nRAS, 1);
    chk({tag, "/cas_rel"}, nCAS, 4'hF);
    rel_n = n;
  endtask

  // Services any refresh that would otherwise expire during the next access.
  task automatic guard();
    int p, s;
    p = ((n + R - 1) / R) * R;
    if (p == 0) p = R;
    if (p - n < 48) begin
      s = (rel_n + TRP > p + 1) ? rel_n + TRP : p + 1;
      check_refresh("ref", s);
    end
  endtask

  task automatic access(input string tag, input logic [AW-1:0] addr, input logic rnw,
                        input logic [1:0] siz, input int nds_wait, input int hold,
                        input bit ref_first, input bit abort, input bit rst_mid);
    int start, fall, cas_e;
    logic [ROW_BITS-1:0] row, col;
    logic [3:0] lanes;
    row   = ROW_BITS'((int'(addr) >> 2) / (1 << COL_BITS));
    col   = ROW_BITS'((int'(addr) >> 2) % (1 << COL_BITS));
    lanes = exp_lanes(rnw, siz, addr[1:0]);
    ADDR = addr; RnW = rnw; SIZ = siz; nDRAMSEL = 1'b0; nAS = 1'b0;
    nDS  = rnw ? 1'b0 : 1'b1;
    start = n;
    if (ref_first) check_refresh({tag, "/ref"}, start + 2);
    fall = (rel_n + TRP > start + 2) ? rel_n + TRP : start + 2;
    while (n < fall - 1) begin
      step();
      chk({tag, "/pre_ras"}, nRAS, 1);
      chk({tag, "/pre_dsack"}, DSACK, 2'b00);
    end
    step();
    chk({tag, "/ras_fall"}, nRAS, 0);
    chk({tag, "/ma_row"}, MA, row);
    chk({tag, "/nwe"}, nWE, rnw);
    chk({tag, "/rcd_cas"}, nCAS, 4'hF);
    chk({tag, "/rcd_dsack"}, DSACK, 2'b00);
    if (abort) begin
      nAS = 1'b1; nDS = 1'b1; nDRAMSEL = 1'b1;
      step();
      chk({tag, "/abort_ras"}, nRAS, 1);
      chk({tag, "/abort_nwe"}, nWE, 1);
      chk({tag, "/abort_cas"}, nCAS, 4'hF);
      chk({tag, "/abort_dsack"}, DSACK, 2'b00);
      rel_n = n;
      repeat (TRP) begin
        step();
        chk({tag, "/abort_pre_ras"}, nRAS, 1);
        chk({tag, "/abort_pre_cas"}, nCAS, 4'hF);
        chk({tag, "/abort_pre_dsack"}, DSACK, 2'b00);
      end
      return;
    end
    cas_e = fall + TRCD;
    if (!rnw && fall + nds_wait + 1 > cas_e) cas_e = fall + nds_wait + 1;
    for (int e = fall + 1; e <= cas_e; e++) begin
      if (!rnw && e - 1 == fall + nds_wait) nDS = 1'b0;
      step();
      if (e < cas_e) begin
        chk({tag, "/ma_col_wait"}, MA, col);
        chk({tag, "/wait_cas"}, nCAS, 4'hF);
        chk({tag, "/wait_dsack"}, DSACK, 2'b00);
        chk({tag, "/wait_ras"}, nRAS, 0);
      end
    end
    chk({tag, "/cas"}, nCAS, lanes);
    chk({tag, "/dsack"}, DSACK, 2'b11);
    chk({tag, "/cas_ras"}, nRAS, 0);
    chk({tag, "/cas_nwe"}, nWE, rnw);
    chk({tag, "/ma_col"}, MA, col);
    repeat (hold) begin
      step();
      chk({tag, "/hold_cas"}, nCAS, lanes);
      chk({tag, "/hold_dsack"}, DSACK, 2'b11);
      chk({tag, "/hold_ras"}, nRAS, 0);
    end
    if (rst_mid) begin
      nRST = 1'b0;
      #1;
      chk({tag, "/rst_ras"}, nRAS, 1);
      chk({tag, "/rst_cas"}, nCAS, 4'hF);
      chk({tag, "/rst_nwe"}, nWE, 1);
      chk({tag, "/rst_dsack"}, DSACK, 2'b00);
      chk({tag, "/rst_ma"}, MA, 0);
      nAS = 1'b1; nDS = 1'b1; nDRAMSEL = 1'b1;
      step();
      nRST  = 1'b1;
      rel_n = -100;
      return;
    end
    nAS = 1'b1; nDS = 1'b1; nDRAMSEL = 1'b1;
    step();
    chk({tag, "/rel_ras"}, nRAS, 1);
    chk({tag, "/rel_cas"}, nCAS, 4'hF);
    chk({tag, "/rel_nwe"}, nWE, 1);
    chk({tag, "/rel_dsack"}, DSACK, 2'b00);
    rel_n = n;
  endtask

  initial begin
    int p, ph, gap;
    logic [AW-1:0] a;
    logic rnw;
    logic [1:0] siz;

    // Clock/reset
    #2 nRST = 1'b0;
    #3;
    chk("reset/ras", nRAS, 1);
    chk("reset/cas", nCAS, 4'hF);
    chk("reset/nwe", nWE, 1);
    chk("reset/dsack", DSACK, 2'b00);
    chk("reset/ma", MA, 0);
    step();
    nRST = 1'b1;

    // Idle refresh cadence on the short-interval instance
    for (int i = 0; i < 50; i++) begin
      step();
      ph = n % R16;
      chk("t4/ncas", r_ncas, (n > R16 && ph >= 1 && ph <= 1 + TRAS) ? 4'h0 : 4'hF);
      chk("t4/nras", r_nras, (n > R16 && ph >= 2 && ph <= 1 + TRAS) ? 1'b0 : 1'b1);
      chk("t4/dsack", r_dsack, 2'b00);
      chk("t4/nwe", r_nwe, 1);
    end

    // Strobe outside the RAM region must not start a cycle
    guard();
    nAS = 1'b0; nDRAMSEL = 1'b1; nDS = 1'b0;
    repeat (4) begin
      step();
      chk("nosel/ras", nRAS, 1);
    end
    nAS = 1'b1; nDS = 1'b1;
    step();

    // Long read, then an immediate second read to measure precharge
    guard();
    access("t2", 24'h12_3458, 1'b1, 2'b00, 0, 2, 1'b0, 1'b0, 1'b0);
    chk("t2/row_const", MA, 11'h516);
    access("t2b", 24'h12_3458, 1'b1, 2'b00, 0, 1, 1'b0, 1'b0, 1'b0);

    // Byte write at offset 2 with late data strobe
    guard();
    access("t3", 24'h12_345A, 1'b0, 2'b01, 3, 1, 1'b0, 1'b0, 1'b0);

    // Abort one clock after nRAS fall
    guard();
    access("t6", 24'h0A_BCD0, 1'b1, 2'b00, 0, 1, 1'b0, 1'b1, 1'b0);
    access("t6b", 24'h03_0004, 1'b1, 2'b10, 0, 1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of HOLD, then a fresh cycle
    guard();
    access("t1", 24'h00_1238, 1'b0, 2'b10, 0, 2, 1'b0, 1'b0, 1'b1);
    chk("t1/after_n", n, 0);
    access("t1b", 24'h00_1238, 1'b1, 2'b00, 0, 1, 1'b0, 1'b0, 1'b0);

    // Refresh pending and request on the same edge
    guard();
    p = (n / R + 1) * R;
    while (n < p - 1) step();
    access("t5", 24'h12_3458, 1'b1, 2'b00, 0, 1, 1'b1, 1'b0, 1'b0);

    // Randomized accesses
    for (int i = 0; i < 30; i++) begin
      guard();
      gap = $urandom_range(0, 2);
      repeat (gap) step();
      a   = AW'($urandom);
      rnw = 1'($urandom_range(0, 1));
      siz = 2'($urandom_range(0, 3));
      access("rnd", a, rnw, siz, $urandom_range(0, 4), $urandom_range(1, 3), 1'b0,
             $urandom_range(0, 7) == 0, 1'b0);
    end

    // Idle through refreshes on the main instance
    repeat (2) begin
      p = (n / R + 1) * R;
      check_refresh("ref_idle", (rel_n + TRP > p + 1) ? rel_n + TRP : p + 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
